microcode_seq: RTL and testbench

Microcode sequencer that sits directly upstream of the KPU datapath (register file, tmp0/tmp1, MLU, shifter, bus mux).
- Accepts a latched 32-bit opcode word via a valid/ready handshake.
- Dispatches into the microcode SRAM and steps a micro-PC, one microword per cycle.
- Decodes each microword into the datapath control strobes, and enforces the single-bus-driver rule in hardware.

---
 rtl/kpu_pkg.sv | 65 ++++++
 rtl/microword_decode.sv | 51 +++++
 rtl/microcode_seq.sv | 135 +++++++++++++
 tb/tb_microcode_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/kpu_pkg.sv
// rtl/kpu_pkg.sv - microword/opcode field map, sequencer state and control-strobe types for the KPU
package kpu_pkg;

    // Microword field positions
    localparam int MW_MLU_OP_LSB     = 0;
    localparam int MW_MLU_N_OE       = 3;
    localparam int MW_SHIFTER_OP_LSB = 4;
    localparam int MW_SHIFTER_N_OE   = 6;
    localparam int MW_REG_N_OE       = 7;
    localparam int MW_REG_N_WE       = 8;
    localparam int MW_REG_SRC_LSB    = 9;
    localparam int MW_LITERAL_LSB    = 11;
    localparam int MW_TMP0_WE        = 16;
    localparam int MW_TMP1_WE        = 17;
    localparam int MW_WAIT_MEM       = 18;
    localparam int MW_END            = 19;

    // Opcode word field positions
    localparam int OPW_OP_LSB     = 0;
    localparam int OPW_OP_W       = 6;
    localparam int OPW_REG0_LSB   = 6;
    localparam int OPW_REG1_LSB   = 11;
    localparam int OPW_REG_W      = 5;
    localparam int OPW_OFFSET_LSB = 16;
    localparam int OPW_OFFSET_W   = 16;

    typedef enum logic [1:0] {
        REG_SRC_REG0 = 2'd0,
        REG_SRC_REG1 = 2'd1,
        REG_SRC_LIT  = 2'd2,
        REG_SRC_RSVD = 2'd3
    } reg_src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_ERR   = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [2:0] mlu_op;
        logic       mlu_n_oe;
        logic [1:0] shifter_op;
        logic       shifter_n_oe;
        logic [4:0] reg_sel;
        logic       reg_n_oe;
        logic       reg_n_we;
        logic       tmp0_we;
        logic       tmp1_we;
    } ctrl_t;

    localparam ctrl_t CTRL_INACTIVE = '{
        mlu_op:       3'd0,
        mlu_n_oe:     1'b1,
        shifter_op:   2'd0,
        shifter_n_oe: 1'b1,
        reg_sel:      5'd0,
        reg_n_oe:     1'b1,
        reg_n_we:     1'b1,
        tmp0_we:      1'b0,
        tmp1_we:      1'b0
    };

endpackage

// File: rtl/microword_decode.sv
// rtl/microword_decode.sv - combinational microword decode into datapath strobes plus bus-conflict/reserved-source fault
module microword_decode
    import kpu_pkg::*;
#(
    parameter int UWORD_W = 32
) (
    input  logic [UWORD_W-1:0] ucode_data,
    input  logic [4:0]         reg0,
    input  logic [4:0]         reg1,
    output ctrl_t              ctrl,
    output logic               wait_mem,
    output logic               end_op,
    output logic               fault
);

    reg_src_e   reg_src;
    logic [1:0] bus_drivers;
    logic       unused_rsvd;

    assign reg_src = reg_src_e'(ucode_data[MW_REG_SRC_LSB +: 2]);

    always_comb begin
        ctrl              = CTRL_INACTIVE;
        ctrl.mlu_op       = ucode_data[MW_MLU_OP_LSB +: 3];
        ctrl.mlu_n_oe     = ucode_data[MW_MLU_N_OE];
        ctrl.shifter_op   = ucode_data[MW_SHIFTER_OP_LSB +: 2];
        ctrl.shifter_n_oe = ucode_data[MW_SHIFTER_N_OE];
        ctrl.reg_n_oe     = ucode_data[MW_REG_N_OE];
        ctrl.reg_n_we     = ucode_data[MW_REG_N_WE];
        ctrl.tmp0_we      = ucode_data[MW_TMP0_WE];
        ctrl.tmp1_we      = ucode_data[MW_TMP1_WE];
        case (reg_src)
            REG_SRC_REG0: ctrl.reg_sel = reg0;
            REG_SRC_REG1: ctrl.reg_sel = reg1;
            REG_SRC_LIT:  ctrl.reg_sel = ucode_data[MW_LITERAL_LSB +: 5];
            default:      ctrl.reg_sel = 5'd0;
        endcase
    end

    // Count of sources trying to drive the shared bus (active-low enables)
    assign bus_drivers = {1'b0, ~ucode_data[MW_MLU_N_OE]}
                       + {1'b0, ~ucode_data[MW_SHIFTER_N_OE]}
                       + {1'b0, ~ucode_data[MW_REG_N_OE]};

    assign fault    = (bus_drivers > 2'd1) || (reg_src == REG_SRC_RSVD);
    assign wait_mem = ucode_data[MW_WAIT_MEM];
    assign end_op   = ucode_data[MW_END];

    assign unused_rsvd = ^ucode_data[UWORD_W-1:MW_END+1];

endmodule

// File: rtl/microcode_seq.sv
// rtl/microcode_seq.sv - KPU microcode sequencer top; MICROCODE_SEQ_SINGLE_STEP_EN adds a STEP gate on EXEC
module microcode_seq
    import kpu_pkg::*;
#(
    parameter int UADDR_W = 12,
    parameter int UWORD_W = 32,
    parameter int SLOT_W  = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [31:0]        OP_WORD,
    input  logic               OP_VALID,
    output logic               OP_READY,
    output logic [UADDR_W-1:0] UCODE_ADDR,
    input  logic [UWORD_W-1:0] UCODE_DATA,
    input  logic               MEM_READY,
`ifdef MICROCODE_SEQ_SINGLE_STEP_EN
    input  logic               STEP,
`endif
    output logic [2:0]         MLU_OP,
    output logic               MLU_N_OE,
    output logic [1:0]         SHIFTER_OP,
    output logic               SHIFTER_N_OE,
    output logic [4:0]         REG_SEL,
    output logic               REG_N_OE,
    output logic               REG_N_WE,
    output logic               TMP0_WE,
    output logic               TMP1_WE,
    output logic               BUSY,
    output logic               ERR
);

    seq_state_e         state_q, state_d;
    logic [UADDR_W-1:0] addr_q, addr_d;
    logic [4:0]         reg0_q, reg1_q;
    ctrl_t              dec_ctrl, ctrl;
    logic               dec_wait_mem, dec_end, dec_fault;
    logic               op_accept, advance, mem_stall, hold, slot_last;
    logic               unused_offset;

    microword_decode #(
        .UWORD_W (UWORD_W)
    ) u_decode (
        .ucode_data (UCODE_DATA),
        .reg0       (reg0_q),
        .reg1       (reg1_q),
        .ctrl       (dec_ctrl),
        .wait_mem   (dec_wait_mem),
        .end_op     (dec_end),
        .fault      (dec_fault)
    );

`ifdef MICROCODE_SEQ_SINGLE_STEP_EN
    assign advance = STEP;
`else
    assign advance = 1'b1;
`endif

    assign op_accept = (state_q == ST_IDLE) && OP_VALID;
    assign mem_stall = dec_wait_mem && !MEM_READY;
    assign hold      = (state_q == ST_EXEC) && (!advance || mem_stall);
    assign slot_last = &addr_q[SLOT_W-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            reg0_q  <= '0;
            reg1_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (op_accept) begin
                reg0_q <= OP_WORD[OPW_REG0_LSB +: OPW_REG_W];
                reg1_q <= OP_WORD[OPW_REG1_LSB +: OPW_REG_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (OP_VALID) begin
                    state_d = ST_FETCH;
                    addr_d  = {OP_WORD[OPW_OP_LSB +: OPW_OP_W], {SLOT_W{1'b0}}};
                end
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                // Fault beats stall so a conflicting word can never sit on the bus
                if (advance) begin
                    if (dec_fault)      state_d = ST_ERR;
                    else if (mem_stall) state_d = ST_EXEC;
                    else if (dec_end)   state_d = ST_IDLE;
                    else if (slot_last) state_d = ST_ERR;
                    else                addr_d  = addr_q + UADDR_W'(1);
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    always_comb begin
        ctrl = CTRL_INACTIVE;
        if ((state_q == ST_EXEC) && !dec_fault) begin
            ctrl = dec_ctrl;
            // A held word repeats its bus drive, but writes land only on the release cycle
            if (hold) begin
                ctrl.reg_n_we = 1'b1;
                ctrl.tmp0_we  = 1'b0;
                ctrl.tmp1_we  = 1'b0;
            end
        end
    end

    assign OP_READY     = (state_q == ST_IDLE);
    assign BUSY         = (state_q != ST_IDLE);
    assign ERR          = (state_q == ST_ERR);
    assign UCODE_ADDR   = addr_q;
    assign MLU_OP       = ctrl.mlu_op;
    assign MLU_N_OE     = ctrl.mlu_n_oe;
    assign SHIFTER_OP   = ctrl.shifter_op;
    assign SHIFTER_N_OE = ctrl.shifter_n_oe;
    assign REG_SEL      = ctrl.reg_sel;
    assign REG_N_OE     = ctrl.reg_n_oe;
    assign REG_N_WE     = ctrl.reg_n_we;
    assign TMP0_WE      = ctrl.tmp0_we;
    assign TMP1_WE      = ctrl.tmp1_we;

    assign unused_offset = ^OP_WORD[OPW_OFFSET_LSB +: OPW_OFFSET_W];

endmodule

// File: tb/tb_microcode_seq.sv
// tb/tb_microcode_seq.sv - directed self-checking bench for microcode_seq with a behavioural microcode SRAM
module tb_microcode_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] OP_WORD = 32'h0;
    logic        OP_VALID = 1'b0;
    logic        OP_READY;
    logic [11:0] UCODE_ADDR;
    logic [31:0] UCODE_DATA = 32'h0;
    logic        MEM_READY = 1'b1;
    logic [2:0]  MLU_OP;
    logic        MLU_N_OE;
    logic [1:0]  SHIFTER_OP;
    logic        SHIFTER_N_OE;
    logic [4:0]  REG_SEL;
    logic        REG_N_OE;
    logic        REG_N_WE;
    logic        TMP0_WE;
    logic        TMP1_WE;
    logic        BUSY;
    logic        ERR;
`ifdef MICROCODE_SEQ_SINGLE_STEP_EN
    logic        STEP = 1'b1;
`endif

    logic [31:0] mem [0:4095];
    int          errors = 0;
    int          checks = 0;
    int          pulses;
    logic [15:0] obs_ctrl;
    logic [15:0] inactive;

    localparam logic [31:0] NOP    = 32'h0000_01C8;
    localparam logic [31:0] W0     = 32'h0002_02C3;
    localparam logic [31:0] W1     = 32'h0001_ADA8;
    localparam logic [31:0] W1_WT  = 32'h0005_ADA8;
    localparam logic [31:0] W2_END = 32'hFFF8_014D;

    microcode_seq dut (
        .CLK          (CLK),
        .RST          (RST),
        .OP_WORD      (OP_WORD),
        .OP_VALID     (OP_VALID),
        .OP_READY     (OP_READY),
        .UCODE_ADDR   (UCODE_ADDR),
        .UCODE_DATA   (UCODE_DATA),
        .MEM_READY    (MEM_READY),
`ifdef MICROCODE_SEQ_SINGLE_STEP_EN
        .STEP         (STEP),
`endif
        .MLU_OP       (MLU_OP),
        .MLU_N_OE     (MLU_N_OE),
        .SHIFTER_OP   (SHIFTER_OP),
        .SHIFTER_N_OE (SHIFTER_N_OE),
        .REG_SEL      (REG_SEL),
        .REG_N_OE     (REG_N_OE),
        .REG_N_WE     (REG_N_WE),
        .TMP0_WE      (TMP0_WE),
        .TMP1_WE      (TMP1_WE),
        .BUSY         (BUSY),
        .ERR          (ERR)
    );

    always #5 CLK = ~CLK;

    // Read port registered on the falling edge so the word for UCODE_ADDR is valid in its own cycle
    always @(negedge CLK) UCODE_DATA <= mem[UCODE_ADDR];

    assign obs_ctrl = {MLU_OP, MLU_N_OE, SHIFTER_OP, SHIFTER_N_OE, REG_SEL,
                       REG_N_OE, REG_N_WE, TMP0_WE, TMP1_WE};

    function automatic logic [15:0] exp_ctrl(input logic [2:0] mo, input logic mn,
                                             input logic [1:0] so, input logic sn,
                                             input logic [4:0] rs, input logic rn,
                                             input logic rw, input logic t0, input logic t1);
        return {mo, mn, so, sn, rs, rn, rw, t0, t1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic mr, input logic r);
        @(posedge CLK);
        #1;
        OP_VALID  = v;
        MEM_READY = mr;
        RST       = r;
        #5;
    endtask

    initial begin
        inactive = exp_ctrl(3'd0, 1'b1, 2'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4096; i++) mem[i] = NOP;
        mem[12'h140] = W0;
        mem[12'h141] = W1;
        mem[12'h142] = W2_END;
        mem[12'h042] = W0;
        mem[12'h0C0] = 32'h0001_0040;
        mem[12'h100] = 32'h0000_07C8;

        // 1: reset state
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("rst_op_ready", 32'(OP_READY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_addr", 32'(UCODE_ADDR), 32'h000);
        chk("rst_ctrl", 32'(obs_ctrl), 32'(inactive));

        // 2: op 5, three words, END on the third; reg1=7 reg0=9
        OP_WORD = 32'hABCD_3A45;
        cyc(1'b1, 1'b1, 1'b0);
        chk("p2_idle_ready", 32'(OP_READY), 32'd1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("p2_fetch_addr", 32'(UCODE_ADDR), 32'h140);
        chk("p2_fetch_ready", 32'(OP_READY), 32'd0);
        chk("p2_fetch_ctrl", 32'(obs_ctrl), 32'(inactive));
        cyc(1'b0, 1'b1, 1'b0);
        chk("p2_w0_addr", 32'(UCODE_ADDR), 32'h140);
        chk("p2_w0_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(3'd3, 1'b0, 2'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1)));
        cyc(1'b0, 1'b1, 1'b0);
        chk("p2_w1_addr", 32'(UCODE_ADDR), 32'h141);
        chk("p2_w1_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(3'd0, 1'b1, 2'd2, 1'b0, 5'h15, 1'b1, 1'b1, 1'b1, 1'b0)));
        OP_WORD = 32'h0000_3A43;
        cyc(1'b1, 1'b1, 1'b0);
        chk("p2_w2_addr", 32'(UCODE_ADDR), 32'h142);
        chk("p2_w2_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(3'd5, 1'b1, 2'd0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0)));
        chk("p2_w2_ready", 32'(OP_READY), 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("p2_end_ready", 32'(OP_READY), 32'd1);
        chk("p2_end_busy", 32'(BUSY), 32'd0);
        chk("p2_end_no_accept", 32'(UCODE_ADDR), 32'h142);

        // 3: WAIT_MEM on 0x141 with MEM_READY low for three cycles
        mem[12'h141] = W1_WT;
        OP_WORD = 32'hABCD_3A45;
        pulses = 0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("p3_w0_tmp1", 32'(TMP1_WE), 32'd1);
        pulses += int'(TMP0_WE);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("p3_stall%0d_addr", i), 32'(UCODE_ADDR), 32'h141);
            chk($sformatf("p3_stall%0d_ctrl", i), 32'(obs_ctrl),
                32'(exp_ctrl(3'd0, 1'b1, 2'd2, 1'b0, 5'h15, 1'b1, 1'b1, 1'b0, 1'b0)));
            pulses += int'(TMP0_WE);
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk("p3_rel_addr", 32'(UCODE_ADDR), 32'h141);
        chk("p3_rel_tmp0", 32'(TMP0_WE), 32'd1);
        pulses += int'(TMP0_WE);
        cyc(1'b0, 1'b1, 1'b0);
        chk("p3_w2_addr", 32'(UCODE_ADDR), 32'h142);
        pulses += int'(TMP0_WE);
        chk("p3_tmp0_pulses", 32'(pulses), 32'd1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("p3_idle", 32'(OP_READY), 32'd1);

        // 6: reset mid-program at 0x042
        OP_WORD = 32'h0000_3A41;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("p6_pre_addr", 32'(UCODE_ADDR), 32'h042);
        chk("p6_pre_tmp1", 32'(TMP1_WE), 32'd1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("p6_ready", 32'(OP_READY), 32'd1);
        chk("p6_err", 32'(ERR), 32'd0);
        chk("p6_busy", 32'(BUSY), 32'd0);
        chk("p6_addr", 32'(UCODE_ADDR), 32'h000);
        chk("p6_ctrl", 32'(obs_ctrl), 32'(inactive));

        // 5: op 2 has no END in its slot
        OP_WORD = 32'h0000_3A42;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("p5_fetch_addr", 32'(UCODE_ADDR), 32'h080);
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk($sformatf("p5_addr%0d", i), 32'(UCODE_ADDR), 32'h080 + 32'(i));
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk("p5_err", 32'(ERR), 32'd1);
        chk("p5_addr_hold", 32'(UCODE_ADDR), 32'h0BF);
        chk("p5_ready", 32'(OP_READY), 32'd0);
        chk("p5_ctrl", 32'(obs_ctrl), 32'(inactive));
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("p5_rst_err", 32'(ERR), 32'd0);

        // 4: MLU and REG both driving the bus
        OP_WORD = 32'h0000_3A43;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("p4_fault_ctrl", 32'(obs_ctrl), 32'(inactive));
        chk("p4_fault_err", 32'(ERR), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("p4_err", 32'(ERR), 32'd1);
        chk("p4_err_ctrl", 32'(obs_ctrl), 32'(inactive));
        chk("p4_err_ready", 32'(OP_READY), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("p4_sticky", 32'(ERR), 32'd1);
        chk("p4_addr", 32'(UCODE_ADDR), 32'h0C0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("p4_rst_err", 32'(ERR), 32'd0);
        chk("p4_rst_ready", 32'(OP_READY), 32'd1);

        // Reserved REG_SRC
        OP_WORD = 32'h0000_3A44;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("rsvd_ctrl", 32'(obs_ctrl), 32'(inactive));
        cyc(1'b0, 1'b1, 1'b0);
        chk("rsvd_err", 32'(ERR), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
